// File: rtl/alu_share_arbiter_if.sv
// Bundle of the requester-side and consumer-side buses of the shared ALU
// arbiter.
//
// Handshake semantics (both sides): a beat transfers on a rising clock edge
// where valid and ready are both high. A producer holds valid and its payload
// stable until that edge. Ready may depend combinationally on valid, but
// valid never depends on ready.
interface alu_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*2-1:0]     req_sel;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
  logic [7:0]            busy_cnt;

  // Requesters plus consumer: drive operations, accept results
  modport master (
    output req_valid, req_a, req_b, req_sel, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy_cnt
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_a, req_b, req_sel, res_ready,
    output req_ready, res_valid, res_data, res_id, busy_cnt
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one bitwise logic ALU (AND/OR/NAND/NOR) among
// NREQ requesters. One grant per cycle into a single-entry output register
// tagged with the requester index. The register refills in the same cycle it
// drains, so a steadily ready consumer sees one result per cycle.
module alu_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus,
  output logic               dbg_state
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [7:0]       busy_q, busy_d;

  logic             can_accept;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             xfer;
  logic [NREQ-1:0]  ready_oh;
  logic [WIDTH-1:0] op_a, op_b, alu_y;
  logic [1:0]       op_sel;

  // Room for a new result when empty or being drained this cycle
  assign can_accept = (state_q == EMPTY) | bus.res_ready;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % NREQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  // Grant qualification: only with room and never while reset is held
  always_comb begin
    xfer     = grant_found & can_accept & ~rst;
    ready_oh = '0;
    if (xfer) ready_oh[grant_idx] = 1'b1;
  end

  // Operand mux and the shared bitwise ALU
  always_comb begin
    op_a   = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
    op_b   = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
    op_sel = bus.req_sel[int'(grant_idx)*2 +: 2];
    case (op_sel)
      2'b00:   alu_y = op_a & op_b;
      2'b01:   alu_y = op_a | op_b;
      2'b10:   alu_y = ~(op_a & op_b);
      default: alu_y = ~(op_a | op_b);
    endcase
  end

  // Output register next state: load on transfer, empty on pure drain, else hold
  always_comb begin
    state_d      = state_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      state_d      = FULL;
      res_data_d   = alu_y;
      res_id_d     = grant_idx;
      last_grant_d = grant_idx;
    end else if (state_q == FULL && bus.res_ready) begin
      state_d = EMPTY;
    end
  end

  // Stall counter: a request waiting behind a full, undrained register
  always_comb begin
    busy_d = busy_q;
    if (|bus.req_valid && !can_accept && busy_q != 8'hFF) busy_d = busy_q + 8'd1;
  end

  // State registers; reset discards any pending result and rewinds the pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      res_data_q   <= '0;
      res_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      busy_q       <= '0;
    end else begin
      state_q      <= state_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready = ready_oh;
  assign bus.res_valid = (state_q == FULL);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy_cnt  = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a cycle-stepped reference model predicts grants,
// result contents and the stall counter; results go into exp_q when granted
// and are compared while the output register holds them.
module tb_alu_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;
  localparam int EW    = IDW + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0]   exp_q[$];
  logic            m_valid;
  int              m_last;
  logic [7:0]      m_busy;
  logic [NREQ-1:0] m_grant_oh;
  logic [NREQ-1:0] seen_ready;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [1:0] sel);
    case (sel)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  task automatic model_clear();
    m_valid    = 1'b0;
    m_last     = NREQ - 1;
    m_busy     = '0;
    m_grant_oh = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Entered at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic step();
    logic [NREQ-1:0] exp_ready;
    logic [EW-1:0]   e;
    logic            can_acc;
    int              g;
    #1;
    can_acc   = !m_valid || bus.res_ready;
    exp_ready = '0;
    g         = -1;
    if (can_acc) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    seen_ready = bus.req_ready;
    check("req_ready", bus.req_ready, exp_ready);
    check("res_valid", bus.res_valid, m_valid);
    check("dbg_state", dbg_state, m_valid);
    check("sb_depth", exp_q.size(), m_valid ? 1 : 0);
    if (m_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      check("res_id", bus.res_id, e[EW-1:WIDTH]);
      check("res_data", bus.res_data, e[WIDTH-1:0]);
      if (bus.res_ready) void'(exp_q.pop_front());
    end
    if (bus.req_valid != '0 && !can_acc && m_busy != 8'hFF) m_busy++;
    if (g >= 0) begin
      e = {IDW'(g), alu_ref(bus.req_a[g*WIDTH +: WIDTH], bus.req_b[g*WIDTH +: WIDTH],
                            bus.req_sel[g*2 +: 2])};
      exp_q.push_back(e);
      m_last  = g;
      m_valid = 1'b1;
    end else if (m_valid && bus.res_ready) begin
      m_valid = 1'b0;
    end
    m_grant_oh = exp_ready;
    @(posedge clk);
    #1;
    check("busy_cnt", bus.busy_cnt, m_busy);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_busy_cnt", bus.busy_cnt, 0);
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] sel);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_sel[i*2 +: 2]       = sel;
  endtask

  task automatic rand_op(input int i);
    set_op(i, WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)));
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] single_exp[4];
  logic [NREQ-1:0]  rr_exp[5];

  initial begin
    single_exp = '{4'b1000, 4'b1110, 4'b0111, 4'b0001};
    rr_exp     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    model_clear();

    // Single op, all four opcodes
    do_reset();
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      set_op(0, 4'b1100, 4'b1010, 2'(s));
      step();
      check("single_grant", seen_ready, 4'b0001);
      check("single_data", bus.res_data, single_exp[s]);
      check("single_id", bus.res_id, 0);
    end
    bus.req_valid = '0;
    step();

    // Round-robin from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) rand_op(i);
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_grant", seen_ready, rr_exp[i]);
      check("rr_id", bus.res_id, (i % NREQ));
    end
    bus.req_valid = '0;
    step();

    // Backpressure, then grant in the same cycle as the drain
    do_reset();
    set_op(0, 4'b0110, 4'b0011, 2'b00);
    set_op(1, 4'b0101, 4'b0011, 2'b01);
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0001;
    step();
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_no_grant", seen_ready, 0);
      check("bp_data_held", bus.res_data, 4'b0010);
    end
    check("bp_busy", bus.busy_cnt, 3);
    bus.res_ready = 1'b1;
    step();
    check("bp_grant", seen_ready, 4'b0010);
    check("bp_no_bubble", bus.res_valid, 1);
    check("bp_new_id", bus.res_id, 1);
    check("bp_new_data", bus.res_data, 4'b0111);
    bus.req_valid = '0;
    step();

    // Wrap and skip from last_grant=2
    do_reset();
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = 4'b0101;
    step();
    check("wrap_grant0", seen_ready, 4'b0001);
    step();
    check("wrap_grant2", seen_ready, 4'b0100);
    bus.req_valid = '0;
    step();

    // Reset while a result for requester 3 is pending
    do_reset();
    set_op(3, 4'b1111, 4'b0000, 2'b01);
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1000;
    step();
    check("mid_id_before", bus.res_id, 3);
    check("mid_data_before", bus.res_data, 4'b1111);
    rst = 1'b1;
    #1;
    check("mid_async_valid", bus.res_valid, 0);
    check("mid_async_data", bus.res_data, 0);
    check("mid_async_id", bus.res_id, 0);
    check("mid_async_ready", bus.req_ready, 0);
    model_clear();
    bus.req_valid = 4'b1001;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ready", bus.req_ready, 0);
    rst = 1'b0;
    step();
    check("mid_first_grant", seen_ready, 4'b0001);
    step();
    check("mid_second_grant", seen_ready, 4'b1000);
    bus.req_valid = '0;
    step();

    // Stall counter saturation
    do_reset();
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0001;
    step();
    bus.res_ready = 1'b0;
    repeat (300) step();
    check("sat_busy", bus.busy_cnt, 255);
    bus.res_ready = 1'b1;
    bus.req_valid = '0;
    step();

    // Random traffic with random consumer backpressure
    do_reset();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        // A waiting requester keeps its operation unchanged until granted
        if (!(bus.req_valid[i] && !m_grant_oh[i])) begin
          bus.req_valid[i] = ($urandom_range(0, 1) == 1);
          rand_op(i);
        end
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    step();
    step();
    check("final_empty", bus.res_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one 4-bit logic ALU (AND/OR/NAND/NOR) among several requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block grants one requester per cycle, computes the result, and holds it in a single-entry output register tagged with the requester index until the consumer accepts it. It sits between the requesting units and the shared logic datapath and is the only path into that datapath.

## Interface
- WIDTH, 4: operand/result width in bits.
- NREQ, 4: number of requesters (2..8).
- IDW, $clog2(NREQ): width of the requester index.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i presents an operation.
- req_ready  out  NREQ  bit i: requester i's operation is accepted this cycle. One-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- req_sel  in  NREQ*2  opcode; requester i occupies bits [i*2 +: 2]. 00 AND, 01 OR, 10 NAND, 11 NOR.
- res_valid  out  1  the output register holds a result.
- res_ready  in  1  the consumer accepts the result.
- res_data  out  WIDTH  the result.
- res_id  out  IDW  index of the requester that produced res_data.
- busy_cnt  out  8  saturating count of cycles where any req_valid was high but no grant was issued.

## Operation
- Output register states:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
- can_accept = ~res_valid | res_ready. The register can take a new result when it is empty or is being drained in the same cycle.
- Arbitration is combinational. When can_accept is high, search req_valid starting at index (last_grant+1) mod NREQ and wrap around. The first valid index g is granted and req_ready[g]=1; all other req_ready bits are 0.
- When can_accept is low or no req_valid is high, req_ready is all zeros.
- A transfer occurs when req_valid[g] & req_ready[g]. On that edge:
  - res_data <= op(req_a[g], req_b[g], req_sel[g]).
  - res_id <= g.
  - res_valid <= 1.
  - last_grant <= g.
- If FULL and res_ready=1 with no new transfer, the next state is EMPTY. res_data and res_id hold their last values.
- If FULL and res_ready=0, everything holds and req_ready stays 0. This is backpressure.
- Simultaneous drain and grant: the new result replaces the old one and res_valid stays 1. No bubble is inserted.
- last_grant changes only on a transfer.
- ALU results are bitwise and WIDTH bits wide, with no carry.
  - NAND = ~(a&b).
  - NOR = ~(a|b).
- busy_cnt increments when |req_valid & ~can_accept. It saturates at 255 and clears only on reset.
- Requesters must hold req_a, req_b and req_sel stable while req_valid is high and not yet accepted. The arbiter samples them only on the transfer edge.

## Timing
- Reset values:
  - res_valid=0, res_data=0, res_id=0, busy_cnt=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - req_ready=0 while rst is high.
- Latency: a transfer at edge n gives res_valid=1 with its data from after edge n, in cycle n+1.
- Throughput: with res_ready held high, the block sustains one result per cycle.
- Fairness: a continuously valid requester is granted within NREQ transfers.
- Reset asserted mid-operation: a pending result is discarded and the pointer returns to NREQ-1. After the reset edge no req_ready is issued until rst is low.
- req_ready depends combinationally on req_valid, res_valid and res_ready. There is no combinational path from req_a, req_b or req_sel to any output.

## Test plan
- Single op, NREQ=4:
  - Stimulus: req_valid=0001, a=1100, b=1010, sel=00, res_ready=1.
  - Response: req_ready=0001. On the next cycle res_valid=1, res_data=1000, res_id=0.
  - Repeat with sel=01/10/11 and expect res_data=1110 / 0111 / 0001.
- Round-robin:
  - Stimulus: req_valid=1111 held, res_ready=1, from reset.
  - Response: grants go to 0,1,2,3,0 on consecutive cycles, and res_id follows one cycle later.
- Backpressure:
  - Stimulus: result FULL with res_ready=0 for 3 cycles while req_valid=0010.
  - Response: req_ready=0, res_data is stable, busy_cnt=3.
  - After res_ready rises: grant 1 in the same cycle, and the new result appears the next cycle with no bubble.
- Wrap and skip:
  - Stimulus: last_grant=2, req_valid=0101.
  - Response: grant 0, then grant 2.
- Reset mid-flight:
  - Stimulus: assert rst while FULL with res_id=3.
  - Response: outputs go to 0 immediately without waiting for a clock edge. After release, req_valid=1001 is granted to 0 first.
- Saturation:
  - Stimulus: hold FULL with res_ready=0 and any request high for 300 cycles.
  - Response: busy_cnt=255.
